// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA defaults, pixel/axis types and the per-axis bounce step
package vga_pkg;
    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    typedef enum logic {MOVE_POS, MOVE_NEG} dir_t;
    typedef struct packed {
        dir_t        dir;
        logic [11:0] pos;
    } axis_t;
    // Saturates at either edge and reverses on the same tick
    function automatic axis_t bounce(axis_t a, logic [11:0] lim, logic [11:0] step);
        return (a.dir == MOVE_POS)
            ? ((a.pos + step >= lim) ? axis_t'{MOVE_NEG, lim} : axis_t'{MOVE_POS, a.pos + step})
            : ((a.pos <= step) ? axis_t'{MOVE_POS, 12'd0} : axis_t'{MOVE_NEG, a.pos - step});
    endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register for {blank_n, sync_n, hSync_n, vSync_n}, reset to inactive
module vga_sync_delay #(
    parameter int         DEPTH = 2,
    parameter logic [3:0] RST_V = 4'b0111
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    logic [DEPTH-1:0][3:0] sr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= {DEPTH{RST_V}};
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end
    assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_box_renderer.sv
// vga_box_renderer: 2-stage bouncing-box pixel generator; VGA_CHECKER_EN selects a 32x32 checker background
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   BOX_W    = 64,
    parameter int   BOX_H    = 48,
    parameter int   STEP     = 2,
    parameter rgb_t BOX_RGB  = 24'hFF0000,
    parameter rgb_t BG_RGB   = 24'h000040
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [10:0] nextX,
    input  logic [9:0]  nextY,
    input  logic        blank_n,
    input  logic        sync_n,
    input  logic        hSync_n,
    input  logic        vSync_n,
    input  logic        motionEn,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        blankOut_n,
    output logic        syncOut_n,
    output logic        hSyncOut_n,
    output logic        vSyncOut_n
);
    localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - BOX_H);
    localparam logic [11:0] BW    = 12'(BOX_W);
    localparam logic [11:0] BH    = 12'(BOX_H);
    localparam logic [11:0] STP   = 12'(STEP);

    axis_t       ax_q, ax_d, ay_q, ay_d;
    logic        vs_q, blank_q, in_box_q, in_box_d, tick;
    logic [11:0] px, py;
    rgb_t        rgb_q, rgb_d, bg;

    assign px   = {1'b0, nextX};
    assign py   = {2'b0, nextY};
    assign tick = vs_q & ~vSync_n;

    always_comb begin
        ax_d     = (tick && motionEn) ? bounce(ax_q, X_MAX, STP) : ax_q;
        ay_d     = (tick && motionEn) ? bounce(ay_q, Y_MAX, STP) : ay_q;
        in_box_d = (px >= ax_q.pos) && (px < ax_q.pos + BW) && (py >= ay_q.pos) && (py < ay_q.pos + BH);
        rgb_d    = !blank_q ? rgb_t'(24'h0) : in_box_q ? BOX_RGB : bg;
    end

`ifdef VGA_CHECKER_EN
    logic chk_q;
    always_ff @(posedge Clock) chk_q <= Reset ? 1'b0 : nextX[5] ^ nextY[5];
    assign bg = chk_q ? rgb_t'(24'h0) : BG_RGB;
`else
    assign bg = BG_RGB;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ax_q     <= axis_t'{MOVE_POS, 12'd0};
            ay_q     <= axis_t'{MOVE_POS, 12'd0};
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
            in_box_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            vs_q     <= vSync_n;
            blank_q  <= blank_n;
            in_box_q <= in_box_d;
            rgb_q    <= rgb_d;
        end
    end

    vga_sync_delay #(.DEPTH(2), .RST_V(4'b0111)) u_sync (
        .clk_i (Clock),
        .rst_i (Reset),
        .d_i   ({blank_n, sync_n, hSync_n, vSync_n}),
        .q_o   ({blankOut_n, syncOut_n, hSyncOut_n, vSyncOut_n})
    );

    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;
endmodule

// File: tb/tb_vga_box_renderer.sv
// tb_vga_box_renderer: directed + random stimulus checked against a behavioural box/pipeline model
module tb_vga_box_renderer;
    logic        Clock = 0, Reset = 1;
    logic [10:0] nextX = 0;
    logic [9:0]  nextY = 0;
    logic        blank_n = 0, sync_n = 1, hSync_n = 1, vSync_n = 1, motionEn = 1;
    logic [7:0]  red, green, blue;
    logic        blankOut_n, syncOut_n, hSyncOut_n, vSyncOut_n;

    vga_box_renderer dut (
        .Clock(Clock), .Reset(Reset), .nextX(nextX), .nextY(nextY),
        .blank_n(blank_n), .sync_n(sync_n), .hSync_n(hSync_n), .vSync_n(vSync_n),
        .motionEn(motionEn), .red(red), .green(green), .blue(blue),
        .blankOut_n(blankOut_n), .syncOut_n(syncOut_n),
        .hSyncOut_n(hSyncOut_n), .vSyncOut_n(vSyncOut_n)
    );

    always #10 Clock = ~Clock;

    localparam logic [27:0] RST_OUT = {24'h0, 4'b0111};
    int          passes = 0, checks = 0;
    int          bx = 0, by = 0, dx = 1, dy = 1;
    logic        pvs = 1;
    logic [27:0] p1 = RST_OUT, p2 = RST_OUT;

    function automatic logic [23:0] bgat(int x, int y);
`ifdef VGA_CHECKER_EN
        return (((x / 32) + (y / 32)) % 2 == 1) ? 24'h000000 : 24'h000040;
`else
        return 24'h000040;
`endif
    endfunction

    function automatic logic [23:0] colour(int x, int y, logic b);
        if (!b) return 24'h0;
        if (x >= bx && x < bx + 64 && y >= by && y < by + 48) return 24'hFF0000;
        return bgat(x, y);
    endfunction

    task automatic move(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + 2 >= lim) begin p = lim; d = -1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; d = 1; end
            else p = p - 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        logic [27:0] n;
        n = {colour(int'(nextX), int'(nextY), blank_n), blank_n, sync_n, hSync_n, vSync_n};
        @(posedge Clock);
        if (Reset) begin
            p1 = RST_OUT; p2 = RST_OUT; bx = 0; by = 0; dx = 1; dy = 1; pvs = 1;
        end else begin
            p2 = p1;
            p1 = n;
            if (pvs && !vSync_n && motionEn) begin
                move(bx, dx, 736);
                move(by, dy, 552);
            end
            pvs = vSync_n;
        end
        #1 chk("pipe", {4'h0, red, green, blue, blankOut_n, syncOut_n, hSyncOut_n, vSyncOut_n}, {4'h0, p2});
    endtask

    task automatic probe(input int x, input int y, input logic [23:0] exp, input string tag);
        nextX = 11'(x); nextY = 10'(y);
        cyc();
        cyc();
        chk(tag, {8'h0, red, green, blue}, {8'h0, exp});
    endtask

    task automatic tickf();
        vSync_n = 0; cyc();
        vSync_n = 1; cyc();
    endtask

    task automatic edges();
        int xs[6], ys[6];
        xs = '{bx - 1, bx, bx + 63, bx + 64, bx, bx};
        ys = '{by, by, by, by, by - 1, by + 48};
        for (int i = 0; i < 6; i++) begin
            nextX = 11'(xs[i]); nextY = 10'(ys[i]);
            cyc();
        end
        cyc();
        cyc();
    endtask

    initial begin
        Reset = 1; blank_n = 0;
        cyc(); cyc();
        chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("rst_hs", {31'h0, hSyncOut_n}, 32'h1);
        chk("rst_blank", {31'h0, blankOut_n}, 32'h0);
        Reset = 0; blank_n = 1; nextX = 0; nextY = 0;
        cyc();
        chk("pre_rgb", {8'h0, red, green, blue}, 32'h0);
        cyc();
        chk("box00", {8'h0, red, green, blue}, 32'hFF0000);
        probe(63, 10, 24'hFF0000, "x63");
        probe(64, 10, bgat(64, 10), "x64");

        hSync_n = 0; cyc();
        chk("hs_e1", {31'h0, hSyncOut_n}, 32'h1);
        cyc();
        chk("hs_e2", {31'h0, hSyncOut_n}, 32'h0);
        cyc();
        chk("hs_e3", {31'h0, hSyncOut_n}, 32'h0);
        hSync_n = 1; cyc();
        chk("hs_e4", {31'h0, hSyncOut_n}, 32'h0);
        cyc();
        chk("hs_e5", {31'h0, hSyncOut_n}, 32'h1);

        repeat (10) tickf();
        probe(20, 20, 24'hFF0000, "p20_20");
        probe(19, 20, bgat(19, 20), "p19_20");
`ifdef VGA_CHECKER_EN
        probe(32, 0, 24'h000000, "chk32_0");
        probe(0, 32, 24'h000000, "chk0_32");
        probe(100, 100, 24'h000040, "chk100");
`endif

        repeat (300) begin
            nextX    = 11'($urandom_range(0, 140));
            nextY    = 10'($urandom_range(0, 100));
            blank_n  = $urandom_range(0, 3) != 0;
            sync_n   = 1'($urandom);
            hSync_n  = 1'($urandom);
            vSync_n  = $urandom_range(0, 7) != 0;
            motionEn = 1'($urandom);
            cyc();
        end
        blank_n = 1; sync_n = 1; hSync_n = 1; vSync_n = 1; motionEn = 1;

        Reset = 1; cyc(); cyc();
        Reset = 0; nextY = 5;
        for (int x = 0; x < 10; x++) begin
            nextX = 11'(x);
            cyc();
        end
        Reset = 1; cyc();
        chk("mid_rgb", {8'h0, red, green, blue}, 32'h0);
        chk("mid_blank", {31'h0, blankOut_n}, 32'h0);
        cyc();
        Reset = 0;
        probe(0, 0, 24'hFF0000, "origin");
        probe(64, 0, bgat(64, 0), "origin_r");

        repeat (367) begin tickf(); edges(); end
        tickf();
        probe(736, 368, 24'hFF0000, "xsat");
        probe(735, 368, bgat(735, 368), "xsat_l");
        probe(799, 368, 24'hFF0000, "xsat_r");
        probe(736, 416, bgat(736, 416), "ysat_b");
        tickf();
        probe(734, 366, 24'hFF0000, "xrev");
        probe(733, 366, bgat(733, 366), "xrev_l");
        repeat (741) begin tickf(); edges(); end
        motionEn = 0;
        repeat (20) begin tickf(); edges(); end
        probe(724, 12, 24'hFF0000, "hold");
        probe(723, 12, bgat(723, 12), "hold_l");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
